demux1_4_stream: RTL and testbench

Stream demultiplexer, 1 input to 4 outputs. It is the inverse of the 4:1 selection mux used in the datapath. A single WIDTH-bit input beat is routed by a 2-bit select (select1:select0) into one of four one-entry output holding registers, each with its own valid/ready handshake. It is used to distribute ALU/writeback results to four consumers, for example per-stage forwarding buffers, with per-consumer backpressure.

---
 rtl/demux1_4_stream_pkg.sv | 13 +
 rtl/demux1_4_stream_dec2_4.sv | 21 ++
 rtl/demux1_4_stream.sv | 81 ++++++++
 tb/tb_demux1_4_stream.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/demux1_4_stream_pkg.sv
// Shared constants for the 1:4 stream demultiplexer: output count, select width
// and the slot index encoding.
package demux1_4_stream_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  localparam logic [SEL_W-1:0] SLOT_0 = 2'd0;
  localparam logic [SEL_W-1:0] SLOT_1 = 2'd1;
  localparam logic [SEL_W-1:0] SLOT_2 = 2'd2;
  localparam logic [SEL_W-1:0] SLOT_3 = 2'd3;

endpackage

// File: rtl/demux1_4_stream_dec2_4.sv
// Gate-level 2-to-4 one-hot decoder; mirror image of the 4:1 selection mux.
module dec2_4
  import demux1_4_stream_pkg::*;
(
  input  logic               select1,
  input  logic               select0,
  output logic [NUM_OUT-1:0] dec
);

  wire select1_n;
  wire select0_n;

  not u_not1 (select1_n, select1);
  not u_not0 (select0_n, select0);

  and u_and0 (dec[0], select1_n, select0_n);
  and u_and1 (dec[1], select1_n, select0);
  and u_and2 (dec[2], select1,   select0_n);
  and u_and3 (dec[3], select1,   select0);

endmodule

// File: rtl/demux1_4_stream.sv
// 1:4 stream demultiplexer: one input beat is steered by {select1, select0} into
// one of four one-entry holding slots, each with its own valid/ready handshake.
module demux1_4_stream
  import demux1_4_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     select1,
  input  logic                     select0,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [CNT_W-1:0]         accept_cnt
);

  logic [NUM_OUT-1:0]       dec;
  logic [SEL_W-1:0]         sel;
  logic                     acc;
  logic [NUM_OUT-1:0]       drn;

  logic [NUM_OUT*WIDTH-1:0] out_data_d,   out_data_q;
  logic [NUM_OUT-1:0]       out_valid_d,  out_valid_q;
  logic [CNT_W-1:0]         accept_cnt_d, accept_cnt_q;

  dec2_4 u_dec2_4 (
    .select1 (select1),
    .select0 (select0),
    .dec     (dec)
  );

  assign sel      = {select1, select0};
  // Readiness looks only at the selected slot; a full slot being drained this cycle can refill.
  assign in_ready = !out_valid_q[sel] | out_ready[sel];
  assign acc      = in_valid & in_ready;
  assign drn      = out_valid_q & out_ready;

  // Next-state for the slots and the accepted-beat counter.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (acc && dec[k]) begin
        out_data_d[k*WIDTH +: WIDTH] = in_data;
        out_valid_d[k]               = 1'b1;
      end else if (drn[k]) begin
        out_valid_d[k]               = 1'b0;
      end else begin
        out_valid_d[k]               = out_valid_q[k];
      end
    end
    if (acc) begin
      accept_cnt_d = accept_cnt_q + CNT_W'(1);
    end else begin
      accept_cnt_d = accept_cnt_q;
    end
  end

  // State registers with synchronous reset; reset wins over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q   <= {(NUM_OUT*WIDTH){1'b0}};
      out_valid_q  <= {NUM_OUT{1'b0}};
      accept_cnt_q <= {CNT_W{1'b0}};
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      accept_cnt_q <= accept_cnt_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign accept_cnt = accept_cnt_q;

endmodule

// File: tb/tb_demux1_4_stream.sv
// Directed table-driven bench for demux1_4_stream, plus a counter-wrap sequence
// on a second instance with a 4-bit counter.
module tb_demux1_4_stream;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         select1;
  logic         select0;
  logic [3:0]   out_ready;
  logic         in_ready, in_ready_w;
  logic [127:0] out_data, out_data_w;
  logic [3:0]   out_valid, out_valid_w;
  logic [7:0]   accept_cnt;
  logic [3:0]   accept_cnt_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux1_4_stream #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .select1(select1), .select0(select0),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .accept_cnt(accept_cnt)
  );

  demux1_4_stream #(.WIDTH(32), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_w), .select1(select1), .select0(select0),
    .out_data(out_data_w), .out_valid(out_valid_w), .out_ready(out_ready),
    .accept_cnt(accept_cnt_w)
  );

  typedef struct {
    logic         rst;
    logic         vld;
    logic [1:0]   sel;
    logic [31:0]  din;
    logic [3:0]   ordy;
    logic         e_ir;
    logic [3:0]   e_ov;
    logic [7:0]   e_cnt;
    logic [127:0] e_d;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic vld, input logic [1:0] sel,
                              input logic [31:0] din, input logic [3:0] ordy, input logic e_ir,
                              input logic [3:0] e_ov, input logic [7:0] e_cnt,
                              input logic [127:0] e_d);
    vec_t v;
    v.rst = rst; v.vld = vld; v.sel = sel; v.din = din; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_cnt = e_cnt; v.e_d = e_d;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic vld, input logic [1:0] sel,
                       input logic [31:0] din, input logic [3:0] ordy);
    @(negedge clk);
    reset = rst; in_valid = vld; select1 = sel[1]; select0 = sel[0];
    in_data = din; out_ready = ordy;
    #1;
  endtask

  localparam logic [31:0] A  = 32'hA5A5_0001;
  localparam logic [31:0] B1 = 32'h0000_00B1;
  localparam logic [31:0] C  = 32'hCCCC_0002;
  localparam logic [31:0] E0 = 32'hE000_0000;
  localparam logic [31:0] E1 = 32'hE111_1111;
  localparam logic [31:0] E2 = 32'hE222_2222;
  localparam logic [31:0] E3 = 32'hE333_3333;
  localparam logic [31:0] Z  = 32'h0000_0000;

  initial begin
    //              rst   vld   sel   din           ordy     ir    ov       cnt    data {s3,s2,s1,s0}
    vecs[0]  = mk(1'b0, 1'b1, 2'd2, A,            4'b0000, 1'b1, 4'b0100, 8'd1,  {Z, A, Z, Z});
    vecs[1]  = mk(1'b0, 1'b1, 2'd1, B1,           4'b0000, 1'b1, 4'b0110, 8'd2,  {Z, A, B1, Z});
    vecs[2]  = mk(1'b0, 1'b1, 2'd1, C,            4'b0000, 1'b0, 4'b0110, 8'd2,  {Z, A, B1, Z});
    vecs[3]  = mk(1'b0, 1'b1, 2'd3, C,            4'b0000, 1'b1, 4'b1110, 8'd3,  {C, A, B1, Z});
    vecs[4]  = mk(1'b0, 1'b0, 2'd1, 32'hDEAD_BEEF, 4'b1100, 1'b0, 4'b0010, 8'd3, {C, A, B1, Z});
    vecs[5]  = mk(1'b0, 1'b0, 2'd0, 32'hDEAD_BEEF, 4'b0001, 1'b1, 4'b0010, 8'd3, {C, A, B1, Z});
    vecs[6]  = mk(1'b0, 1'b1, 2'd0, 32'h10,       4'b0000, 1'b1, 4'b0011, 8'd4,  {C, A, B1, 32'h10});
    vecs[7]  = mk(1'b0, 1'b1, 2'd0, 32'h1,        4'b0001, 1'b1, 4'b0011, 8'd5,  {C, A, B1, 32'h1});
    vecs[8]  = mk(1'b0, 1'b1, 2'd0, 32'h2,        4'b0001, 1'b1, 4'b0011, 8'd6,  {C, A, B1, 32'h2});
    vecs[9]  = mk(1'b0, 1'b1, 2'd0, 32'h3,        4'b0001, 1'b1, 4'b0011, 8'd7,  {C, A, B1, 32'h3});
    vecs[10] = mk(1'b0, 1'b0, 2'd0, 32'h4,        4'b1111, 1'b1, 4'b0000, 8'd7,  {C, A, B1, 32'h3});
    vecs[11] = mk(1'b0, 1'b1, 2'd0, E0,           4'b0000, 1'b1, 4'b0001, 8'd8,  {C, A, B1, E0});
    vecs[12] = mk(1'b0, 1'b1, 2'd1, E1,           4'b0000, 1'b1, 4'b0011, 8'd9,  {C, A, E1, E0});
    vecs[13] = mk(1'b0, 1'b1, 2'd2, E2,           4'b0000, 1'b1, 4'b0111, 8'd10, {C, E2, E1, E0});
    vecs[14] = mk(1'b0, 1'b1, 2'd3, E3,           4'b0000, 1'b1, 4'b1111, 8'd11, {E3, E2, E1, E0});
    vecs[15] = mk(1'b0, 1'b1, 2'd2, 32'hF5,       4'b0000, 1'b0, 4'b1111, 8'd11, {E3, E2, E1, E0});
    vecs[16] = mk(1'b0, 1'b1, 2'd0, 32'hF5,       4'b0000, 1'b0, 4'b1111, 8'd11, {E3, E2, E1, E0});
    vecs[17] = mk(1'b0, 1'b0, 2'd2, 32'hF6,       4'b0100, 1'b1, 4'b1011, 8'd11, {E3, E2, E1, E0});
    vecs[18] = mk(1'b1, 1'b1, 2'd2, 32'h77,       4'b0000, 1'b1, 4'b0000, 8'd0,  {Z, Z, Z, Z});
    vecs[19] = mk(1'b0, 1'b1, 2'd3, 32'h99,       4'b0000, 1'b1, 4'b1000, 8'd1,  {32'h99, Z, Z, Z});

    reset = 1'b1; in_valid = 1'b0; select1 = 1'b0; select0 = 1'b0;
    in_data = 32'h0; out_ready = 4'b0000;
    repeat (2) @(posedge clk);
    drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
    check("reset_in_ready", {127'd0, in_ready}, 128'd1);
    check("reset_out_valid", {124'd0, out_valid}, 128'd0);
    check("reset_out_data", out_data, 128'd0);
    check("reset_accept_cnt", {120'd0, accept_cnt}, 128'd0);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].sel, vecs[i].din, vecs[i].ordy);
      check($sformatf("v%0d_in_ready", i), {127'd0, in_ready}, {127'd0, vecs[i].e_ir});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), {124'd0, out_valid}, {124'd0, vecs[i].e_ov});
      check($sformatf("v%0d_accept_cnt", i), {120'd0, accept_cnt}, {120'd0, vecs[i].e_cnt});
      check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_d);
    end

    // 17 streamed beats into slot 0: the 4-bit counter wraps through 0 to 1.
    drive(1'b1, 1'b0, 2'd0, 32'h0, 4'b0000);
    @(posedge clk);
    #1;
    check("wrap_reset_cnt", {124'd0, accept_cnt_w}, 128'd0);
    for (int b = 1; b <= 17; b++) begin
      drive(1'b0, 1'b1, 2'd0, b, 4'b0001);
      check($sformatf("wrap_b%0d_in_ready", b), {127'd0, in_ready_w}, 128'd1);
      @(posedge clk);
      #1;
    end
    check("wrap_cnt4", {124'd0, accept_cnt_w}, 128'd1);
    check("wrap_cnt8", {120'd0, accept_cnt}, 128'd17);
    check("wrap_out_valid", {124'd0, out_valid_w}, 128'd1);
    check("wrap_slot0_data", out_data_w, {96'd0, 32'd17});

    drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b0001);
    @(posedge clk);
    #1;
    check("wrap_drained", {124'd0, out_valid_w}, 128'd0);
    check("wrap_cnt_hold", {124'd0, accept_cnt_w}, 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
